pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of performance counters.
REQ-002 clk  input  1  rising-edge clock shared with f_reg..w_reg.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle pulse; begins execution from IDLE.
REQ-005 D_icode, E_icode, M_icode  input  4 each  icode held in D, E, M pipeline registers.
REQ-006 d_srcA, d_srcB  input  4 each  decode-stage source register IDs.
REQ-007 E_dstM  input  4  E-register memory destination ID; 0xF = RNONE.
REQ-008 e_Cnd  input  1  execute-stage branch condition.
REQ-009 m_stat, W_stat  input  3 each  memory-stage status and W-register status.
REQ-010 F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  output  1 each  pipeline register controls.
REQ-011 cpu_state  output  2  FSM state: 0 IDLE, 1 RUN, 2 HALT.
REQ-012 final_stat  output  3  W_stat captured on entry to HALT.
REQ-013 cycle_cnt, stall_cnt, bubble_cnt  output  CNT_W each  performance counters.

Function
REQ-014 Status codes: AOK=1, HLT=2, ADR=3, INS=4; "exceptional" = 2, 3 or 4; all other values count as non-exceptional.
REQ-015 Icodes: MRMOVQ=5, JXX=7, RET=9, POPQ=0xB.
REQ-016 load_use = E_icode in {5,0xB} and E_dstM != 0xF and E_dstM equals d_srcA or d_srcB.
REQ-017 ret_pend = RET present in any of D_icode, E_icode, M_icode.
REQ-018 mispred = E_icode==7 and e_Cnd==0.
REQ-019 Control outputs are combinational from state and current inputs, with zero latency.
REQ-020 IDLE: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, D_stall=0, W_stall=0.
REQ-021 RUN: F_stall = load_use or ret_pend; D_stall = load_use; D_bubble = mispred or (ret_pend and not load_use); E_bubble = mispred or load_use.
REQ-022 RUN: M_bubble = m_stat or W_stat exceptional; W_stall = W_stat exceptional.
REQ-023 HALT: F_stall, D_stall, E_bubble, M_bubble and W_stall all =1, D_bubble=0.
REQ-024 D_stall and D_bubble are never high together in any state.
REQ-025 IDLE->RUN on a clock edge with start=1; start is ignored in RUN and HALT.
REQ-026 RUN->HALT on a clock edge with W_stat exceptional; final_stat<=W_stat on that edge.
REQ-027 HALT is sticky and is left only by reset.
REQ-028 cycle_cnt increments on every RUN-state clock edge.
REQ-029 stall_cnt increments on RUN edges where D_stall=1.
REQ-030 bubble_cnt increments on RUN edges where E_bubble=1.
REQ-031 All counters saturate at 2^CNT_W-1 and do not wrap.
REQ-032 If load_use and mispred occur together, E_bubble=1, D_stall=1 and D_bubble=0 (load-use priority).

Reset
REQ-033 rst_n low asynchronously forces cpu_state=IDLE, final_stat=0 and all counters=0.
REQ-034 While rst_n is low, controls follow IDLE rules; reset mid-RUN or mid-HALT aborts to IDLE with no further counting.
REQ-035 The first rising edge after rst_n deasserts is a normal IDLE edge; start sampled on it is honoured.

Configuration
REQ-036 Macro PIPE_CTRL_PERF_CNT_EN defined: counters are implemented per REQ-028..031.
REQ-037 Macro PIPE_CTRL_PERF_CNT_EN undefined: counter ports remain present, are tied to 0, and no counter flops are synthesised.

Verification
REQ-038 Reset then start pulse -> cpu_state goes 0 to 1 on the next edge; IDLE-cycle controls match REQ-020; cycle_cnt=1 after the first RUN edge.
REQ-039 RUN, E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; stall_cnt and bubble_cnt each +1.
REQ-040 RUN, E_icode=7, e_Cnd=0, no load-use -> D_bubble=E_bubble=1, F_stall=0; with E_dstM=0xF and d_srcA=0xF -> no stall.
REQ-041 RUN, D_icode=9 -> F_stall=1, D_bubble=1 for each cycle RET sits in D, E or M.
REQ-042 RUN, m_stat=3 then W_stat=3 -> M_bubble=1, then W_stall=1; next edge gives cpu_state=2, final_stat=3; start is ignored afterwards.
REQ-043 With CNT_W=4, run 20 cycles -> cycle_cnt holds 15; with the macro undefined, all counters read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: RUN/HALT sequencing, stall/bubble generation and perf counters.
// Optional macro PIPE_CTRL_PERF_CNT_EN enables the saturating performance counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic [1:0]       cpu_state,
  output logic [2:0]       final_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE  = 4'hF;

  function automatic logic is_exc(input logic [2:0] stat);
    return (stat == 3'd2) || (stat == 3'd3) || (stat == 3'd4);
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_final_stat;
  logic       w_load_use;
  logic       w_ret_pend;
  logic       w_mispred;

  assign w_load_use = ((E_icode == IC_MRMOVQ) || (E_icode == IC_POPQ)) &&
                      (E_dstM != REG_NONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_ret_pend = (D_icode == IC_RET) || (E_icode == IC_RET) || (M_icode == IC_RET);
  assign w_mispred  = (E_icode == IC_JXX) && (e_Cnd == 1'b0);

  // State register and halt-status capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_final_stat <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_RUN) && is_exc(W_stat)) begin
        r_final_stat <= W_stat;
      end else begin
        r_final_stat <= r_final_stat;
      end
    end
  end

  // Next state and pipeline register controls; load-use wins over bubbling D
  always_comb begin
    w_state_nxt = r_state;
    F_stall     = 1'b1;
    D_stall     = 1'b0;
    D_bubble    = 1'b1;
    E_bubble    = 1'b1;
    M_bubble    = 1'b1;
    W_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        F_stall  = w_load_use | w_ret_pend;
        D_stall  = w_load_use;
        D_bubble = ~w_load_use & (w_mispred | w_ret_pend);
        E_bubble = w_mispred | w_load_use;
        M_bubble = is_exc(m_stat) | is_exc(W_stat);
        W_stall  = is_exc(W_stat);
        if (is_exc(W_stat)) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
        D_bubble    = 1'b0;
        D_stall     = 1'b1;
        W_stall     = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cpu_state  = r_state;
  assign final_stat = r_final_stat;

`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end else begin
      return v;
    end
  endfunction

  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating counters, advanced only on RUN-state edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt  <= {CNT_W{1'b0}};
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else if (r_state == ST_RUN) begin
      r_cycle_cnt  <= sat_inc(r_cycle_cnt, 1'b1);
      r_stall_cnt  <= sat_inc(r_stall_cnt, D_stall);
      r_bubble_cnt <= sat_inc(r_bubble_cnt, E_bubble);
    end else begin
      r_cycle_cnt  <= r_cycle_cnt;
      r_stall_cnt  <= r_stall_cnt;
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign cycle_cnt  = r_cycle_cnt;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign cycle_cnt  = {CNT_W{1'b0}};
  assign stall_cnt  = {CNT_W{1'b0}};
  assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised self-checking bench for pipe_ctrl against a rule-level model, plus directed scenarios.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, e_Cnd;
  logic [3:0] D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic [1:0] cpu_state;
  logic [2:0] final_stat;
  logic [31:0] cycle_cnt, stall_cnt, bubble_cnt;
  logic F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4;
  logic [1:0] cpu_state4;
  logic [2:0] final_stat4;
  logic [3:0] cycle_cnt4, stall_cnt4, bubble_cnt4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .D_icode(D_icode), .E_icode(E_icode),
    .M_icode(M_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .cpu_state(cpu_state), .final_stat(final_stat), .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .D_icode(D_icode), .E_icode(E_icode),
    .M_icode(M_icode), .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall4), .D_stall(D_stall4),
    .D_bubble(D_bubble4), .E_bubble(E_bubble4), .M_bubble(M_bubble4), .W_stall(W_stall4),
    .cpu_state(cpu_state4), .final_stat(final_stat4), .cycle_cnt(cycle_cnt4),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4));

  // Reference model: mode (0 idle, 1 run, 2 halt), captured status, raw unbounded counts
  int m_mode;
  int m_final;
  longint m_cycles, m_stalls, m_bubbles;
  bit x_fs, x_ds, x_db, x_eb, x_mb, x_ws;

  function automatic bit exc(input logic [2:0] s);
    return (s >= 3'd2) && (s <= 3'd4);
  endfunction

  function automatic longint unsigned expect_cnt(input longint v, input int w);
    longint unsigned lim;
    lim = (64'd1 << w) - 64'd1;
`ifdef PIPE_CTRL_PERF_CNT_EN
    return (v > lim) ? lim : v;
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_final = 0; m_cycles = 0; m_stalls = 0; m_bubbles = 0;
  endtask

  task automatic model_outputs();
    bit lu, rp, mp;
    lu = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'd15 &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    rp = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    mp = (E_icode == 4'd7) && !e_Cnd;
    if (m_mode == 1) begin
      x_fs = lu || rp;
      x_ds = lu;
      x_db = lu ? 1'b0 : (mp || rp);
      x_eb = mp || lu;
      x_mb = exc(m_stat) || exc(W_stat);
      x_ws = exc(W_stat);
    end else if (m_mode == 2) begin
      {x_fs, x_ds, x_db, x_eb, x_mb, x_ws} = 6'b110111;
    end else begin
      {x_fs, x_ds, x_db, x_eb, x_mb, x_ws} = 6'b101110;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if (m_mode == 0 && start) m_mode = 1;
    else if (m_mode == 1) begin
      m_cycles++;
      if (x_ds) m_stalls++;
      if (x_eb) m_bubbles++;
      if (exc(W_stat)) begin
        m_mode = 2;
        m_final = W_stat;
      end
    end
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    model_outputs();
    check("F_stall", F_stall, x_fs);
    check("D_stall", D_stall, x_ds);
    check("D_bubble", D_bubble, x_db);
    check("E_bubble", E_bubble, x_eb);
    check("M_bubble", M_bubble, x_mb);
    check("W_stall", W_stall, x_ws);
    check("ctl4", {F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4},
          {x_fs, x_ds, x_db, x_eb, x_mb, x_ws});
    check("cpu_state", cpu_state, m_mode);
    check("cpu_state4", cpu_state4, m_mode);
    check("final_stat", final_stat, m_final);
    check("final_stat4", final_stat4, m_final);
    check("cycle_cnt", cycle_cnt, expect_cnt(m_cycles, 32));
    check("stall_cnt", stall_cnt, expect_cnt(m_stalls, 32));
    check("bubble_cnt", bubble_cnt, expect_cnt(m_bubbles, 32));
    check("cycle_cnt4", cycle_cnt4, expect_cnt(m_cycles, 4));
    check("stall_cnt4", stall_cnt4, expect_cnt(m_stalls, 4));
    check("bubble_cnt4", bubble_cnt4, expect_cnt(m_bubbles, 4));
  endtask

  // One cycle: inputs already set after a negedge; compare, advance model, cross the edge
  task automatic cyc();
    #1;
    compare_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic neutral();
    start = 1'b0; D_icode = 4'd0; E_icode = 4'd0; M_icode = 4'd0;
    d_srcA = 4'd1; d_srcB = 4'd2; E_dstM = 4'd15; e_Cnd = 1'b1;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] pick_icode();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 4'd5;
      1: return 4'd7;
      2: return 4'd9;
      3: return 4'd11;
      4: return 4'($urandom_range(0, 15));
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] pick_stat(input int rare);
    if ($urandom_range(0, rare) == 0) return 3'($urandom_range(0, 7));
    return 3'd1;
  endfunction

  initial begin
    neutral();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset(3);
    #1;
    check("rst_state", cpu_state, 2'd0);
    check("idle_ctl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, 6'b101110);

    // Start pulse, then the first RUN edge
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_run", cpu_state, 2'd1);
    cyc();
`ifdef PIPE_CTRL_PERF_CNT_EN
    check("cyc_first", cycle_cnt, 32'd1);
`else
    check("cyc_off", cycle_cnt, 32'd0);
`endif

    // Load-use on d_srcB
    E_icode = 4'd5; E_dstM = 4'd3; d_srcB = 4'd3;
    #1;
    check("lu_ctl", {F_stall, D_stall, D_bubble, E_bubble}, 4'b1101);
    cyc();
`ifdef PIPE_CTRL_PERF_CNT_EN
    check("lu_stall_cnt", stall_cnt, 32'd1);
    check("lu_bubble_cnt", bubble_cnt, 32'd1);
`else
    check("lu_cnt_off", stall_cnt | bubble_cnt, 32'd0);
`endif

    // Load-use together with mispredict is impossible on one E_icode; pin no-stall mispredict
    neutral();
    E_icode = 4'd7; e_Cnd = 1'b0; E_dstM = 4'd15; d_srcA = 4'd15;
    #1;
    check("mp_ctl", {F_stall, D_stall, D_bubble, E_bubble}, 4'b0011);
    cyc();

    // RET walking D -> E -> M
    neutral();
    D_icode = 4'd9;
    #1;
    check("ret_d", {F_stall, D_bubble}, 2'b11);
    cyc();
    D_icode = 4'd0; E_icode = 4'd9;
    #1;
    check("ret_e", {F_stall, D_bubble}, 2'b11);
    cyc();
    E_icode = 4'd0; M_icode = 4'd9;
    #1;
    check("ret_m", {F_stall, D_bubble}, 2'b11);
    cyc();

    // Address error through M then W; halt and ignore start
    neutral();
    m_stat = 3'd3;
    #1;
    check("m_exc", {M_bubble, W_stall}, 2'b10);
    cyc();
    m_stat = 3'd1; W_stat = 3'd3;
    #1;
    check("w_exc", {M_bubble, W_stall}, 2'b11);
    cyc();
    check("halt_state", cpu_state, 2'd2);
    check("halt_stat", final_stat, 3'd3);
    neutral();
    start = 1'b1;
    cyc();
    check("halt_sticky", cpu_state, 2'd2);
    check("halt_ctl", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, 6'b110111);

    // 20 RUN cycles on the 4-bit instance
    neutral();
    do_reset(2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (20) cyc();
`ifdef PIPE_CTRL_PERF_CNT_EN
    check("sat4", cycle_cnt4, 4'd15);
`else
    check("sat4_off", cycle_cnt4, 4'd0);
`endif

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 150) == 0) begin
        neutral();
        do_reset($urandom_range(1, 3));
      end
      start   = ($urandom_range(0, 7) == 0);
      D_icode = pick_icode();
      E_icode = pick_icode();
      M_icode = pick_icode();
      d_srcA  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      d_srcB  = 4'($urandom_range(0, 3));
      E_dstM  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      e_Cnd   = 1'($urandom_range(0, 1));
      m_stat  = pick_stat(8);
      W_stat  = pick_stat(40);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
